// File: rtl/ycr_mem_resp_sram_pkg.sv
// ----------------------------------------------------------------------------
// ycr_mem_resp_sram_pkg : response and access-width encodings of the YCR memory
//                         interface, shared by the cross-bar and its targets.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ycr_mem_resp_sram_pkg;

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_OK     = 2'd1;
  localparam logic [1:0] RESP_ER     = 2'd2;
  localparam logic [1:0] RESP_LOK    = 2'd3;

  localparam logic [1:0] WIDTH_BYTE  = 2'd0;
  localparam logic [1:0] WIDTH_HWORD = 2'd1;
  localparam logic [1:0] WIDTH_WORD  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ycr_mem_bemask.sv
// ----------------------------------------------------------------------------
// ycr_mem_bemask : byte-lane write mask and alignment check from access width
//                  and the two low address bits.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ycr_mem_bemask
  import ycr_mem_resp_sram_pkg::*;
(
  input  logic [1:0] width,
  input  logic [1:0] addr_lo,
  output logic [3:0] wmask,
  output logic       misaligned
);

  always_comb begin
    wmask      = 4'h0;
    misaligned = 1'b0;
    case (width)
      WIDTH_BYTE: begin
        wmask = 4'b0001 << addr_lo;
      end
      WIDTH_HWORD: begin
        wmask      = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      WIDTH_WORD: begin
        wmask      = 4'hF;
        misaligned = |addr_lo;
      end
      // Width code 3 is undefined and is rejected like a misaligned access
      default: misaligned = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ycr_mem_resp_sram.sv
// ----------------------------------------------------------------------------
// ycr_mem_resp_sram : YCR memory-interface target that serves single and burst
//                     commands from a single-port, 1-cycle-latency SRAM macro.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ycr_mem_resp_sram
  import ycr_mem_resp_sram_pkg::*;
#(
  parameter int             AW        = 32,
  parameter int             DW        = 32,
  parameter int             BL_W      = 3,
  parameter int             MEM_AW    = 9,
  parameter logic [AW-1:0]  BASE_ADDR = 32'h0C00_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              req_ack,
  input  logic              cmd,
  input  logic [1:0]        width,
  input  logic [AW-1:0]     addr,
  input  logic [BL_W-1:0]   bl,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata,
  output logic [1:0]        resp,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [3:0]        mem_wmask,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_dout
);

  localparam logic [1:0]        ST_IDLE = 2'd0;
  localparam logic [1:0]        ST_RD   = 2'd1;
  localparam logic [1:0]        ST_WR   = 2'd2;
  localparam logic [1:0]        ST_ERR  = 2'd3;
  localparam int                WIN_LSB = MEM_AW + 2;
  localparam logic [BL_W:0]     ONE     = 1;
  localparam logic [MEM_AW-1:0] PTR_ONE = 1;

  logic [1:0]        state, state_d;
  logic              cmd_q, cmd_d;
  logic [1:0]        width_q, width_d;
  logic [BL_W:0]     cnt, cnt_d;
  logic [MEM_AW-1:0] ptr, ptr_d;
  logic              rd_valid, rd_valid_d;
  logic [1:0]        resp_d;
  logic              csb_d, web_d;
  logic [3:0]        wmask_d;
  logic [MEM_AW-1:0] maddr_d;
  logic [DW-1:0]     din_d;

  logic              accept;
  logic [BL_W:0]     beats_in;
  logic [MEM_AW-1:0] word_in;
  logic [3:0]        bemask;
  logic              misaligned;
  logic              err_in;

  function automatic logic [DW-1:0] lane_repl(input logic [1:0] w, input logic [DW-1:0] d);
    case (w)
      WIDTH_BYTE:  lane_repl = {(DW/8){d[7:0]}};
      WIDTH_HWORD: lane_repl = {(DW/16){d[15:0]}};
      default:     lane_repl = d;
    endcase
  endfunction

  ycr_mem_bemask u_bemask (
    .width      (width),
    .addr_lo    (addr[1:0]),
    .wmask      (bemask),
    .misaligned (misaligned)
  );

  assign beats_in = (bl == '0) ? ONE : {1'b0, bl};
  assign word_in  = addr[MEM_AW+1:2];
  assign err_in   = (addr[AW-1:WIN_LSB] != BASE_ADDR[AW-1:WIN_LSB])
                  | misaligned
                  | ((beats_in > ONE) && (width != WIDTH_WORD));
  assign accept   = req & req_ack;

  // A read carries no further beats, so an errored read never acknowledges
  always_comb begin
    req_ack = 1'b0;
    case (state)
      ST_IDLE, ST_WR: req_ack = req;
      ST_ERR:         req_ack = req & cmd_q;
      default:        req_ack = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept) begin
        if ((beats_in == ONE) && (err_in || cmd)) state_d = ST_IDLE;
        else if (err_in)                          state_d = ST_ERR;
        else if (cmd)                             state_d = ST_WR;
        else                                      state_d = ST_RD;
      end
      // No read on the bus means the LOK response is being presented now
      ST_RD:   if (mem_csb) state_d = ST_IDLE;
      ST_WR:   if (accept && (cnt == ONE)) state_d = ST_IDLE;
      ST_ERR:  if ((accept || !cmd_q) && (cnt == ONE)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    resp_d     = RESP_NOTRDY;
    rd_valid_d = 1'b0;
    csb_d      = 1'b1;
    web_d      = 1'b1;
    wmask_d    = 4'h0;
    maddr_d    = mem_addr;
    din_d      = mem_din;
    ptr_d      = ptr;
    cnt_d      = cnt;
    cmd_d      = cmd_q;
    width_d    = width_q;
    case (state)
      ST_IDLE: if (accept) begin
        cmd_d   = cmd;
        width_d = width;
        cnt_d   = beats_in - ONE;
        if (err_in) begin
          resp_d = RESP_ER;
        end else begin
          csb_d   = 1'b0;
          maddr_d = word_in;
          ptr_d   = word_in + PTR_ONE;
          if (cmd) begin
            web_d   = 1'b0;
            wmask_d = bemask;
            din_d   = lane_repl(width, wdata);
            resp_d  = (beats_in == ONE) ? RESP_LOK : RESP_OK;
          end else begin
            cnt_d   = beats_in;
          end
        end
      end
      ST_RD: if (!mem_csb) begin
        resp_d     = (cnt == ONE) ? RESP_LOK : RESP_OK;
        rd_valid_d = 1'b1;
        cnt_d      = cnt - ONE;
        if (cnt != ONE) begin
          csb_d   = 1'b0;
          maddr_d = ptr;
          ptr_d   = ptr + PTR_ONE;
        end
      end
      ST_WR: if (accept) begin
        csb_d   = 1'b0;
        web_d   = 1'b0;
        wmask_d = 4'hF;
        maddr_d = ptr;
        ptr_d   = ptr + PTR_ONE;
        din_d   = lane_repl(width_q, wdata);
        resp_d  = (cnt == ONE) ? RESP_LOK : RESP_OK;
        cnt_d   = cnt - ONE;
      end
      ST_ERR: if (accept || !cmd_q) begin
        resp_d = RESP_ER;
        cnt_d  = cnt - ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= 1'b0;
      width_q   <= WIDTH_BYTE;
      cnt       <= '0;
      ptr       <= '0;
      rd_valid  <= 1'b0;
      resp      <= RESP_NOTRDY;
      mem_csb   <= 1'b1;
      mem_web   <= 1'b1;
      mem_wmask <= 4'h0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      cmd_q     <= cmd_d;
      width_q   <= width_d;
      cnt       <= cnt_d;
      ptr       <= ptr_d;
      rd_valid  <= rd_valid_d;
      resp      <= resp_d;
      mem_csb   <= csb_d;
      mem_web   <= web_d;
      mem_wmask <= wmask_d;
      mem_addr  <= maddr_d;
      mem_din   <= din_d;
    end
  end

  // The macro presents data one cycle after the access; it is qualified here
  assign rdata = rd_valid ? mem_dout : '0;

endmodule

`default_nettype wire

// File: tb/tb_ycr_mem_resp_sram.sv
// ----------------------------------------------------------------------------
// tb_ycr_mem_resp_sram : randomized bench with a cycle-indexed reference model
//                        and an SRAM macro model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ycr_mem_resp_sram;

  localparam int          MAXC = 8192;
  localparam logic [31:0] BASE = 32'h0C00_0000;
  localparam int S_RESP = 0, S_RDATA = 1, S_ADDR = 2, S_MASK = 3, S_DIN = 4, S_CSB = 5, S_ACK = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        cmd = 1'b0;
  logic [1:0]  width = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [2:0]  bl = 3'd0;
  logic [31:0] wdata = 32'h0;
  logic        req_ack;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic        mem_csb, mem_web;
  logic [3:0]  mem_wmask;
  logic [8:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = 32'h0;

  ycr_mem_resp_sram dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ack(req_ack), .cmd(cmd), .width(width),
    .addr(addr), .bl(bl), .wdata(wdata), .rdata(rdata), .resp(resp),
    .mem_csb(mem_csb), .mem_web(mem_web), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro: inputs sampled at the edge, read data on the following cycle
  logic [31:0] sram [512];
  always @(posedge clk) begin
    if (!mem_csb) begin
      if (!mem_web) begin
        for (int i = 0; i < 4; i++)
          if (mem_wmask[i]) sram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
      end else begin
        mem_dout <= sram[mem_addr];
      end
    end
  end

  // Reference model: memory image and expected outputs per cycle
  logic [31:0] ref_mem [512];
  logic [1:0]  e_resp  [MAXC];
  logic [31:0] e_rdata [MAXC];
  logic        e_csb   [MAXC];
  logic        e_web   [MAXC];
  logic [8:0]  e_addr  [MAXC];
  logic [3:0]  e_mask  [MAXC];
  logic [31:0] e_din   [MAXC];
  logic        e_ack   [MAXC];

  typedef struct { int c; int sel; logic [31:0] v; } lit_t;
  lit_t lits[$];

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic clr(input int c);
    e_resp[c] = 2'd0; e_rdata[c] = 32'h0; e_csb[c] = 1'b1; e_web[c] = 1'b1;
    e_addr[c] = 9'd0; e_mask[c] = 4'h0; e_din[c] = 32'h0; e_ack[c] = 1'b0;
  endtask

  task automatic add_lit(input int c, input int sel, input logic [31:0] v);
    lits.push_back('{c, sel, v});
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] w, input int n);
    return (a / 2048 != BASE / 2048) || (w == 2'd1 && a % 2 != 0) ||
           (w == 2'd2 && a % 4 != 0) || (w == 2'd3) || (n > 1 && w != 2'd2);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] w, input logic [31:0] a);
    logic [3:0] m = 4'h0;
    int nb = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    int lo = (w == 2'd2) ? 0 : int'(a % 4);
    for (int i = 0; i < nb; i++) m[lo + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] repl(input logic [1:0] w, input logic [31:0] d);
    if (w == 2'd0) return {4{d[7:0]}};
    if (w == 2'd1) return {2{d[15:0]}};
    return d;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic junk(input bit r);
    req = r; cmd = 1'($urandom); width = 2'($urandom); addr = $urandom;
    bl = 3'($urandom); wdata = $urandom;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] w, input logic [2:0] b,
                    input int abort_k, output int t);
    int n, wi, busy_end;
    bit err, ab;
    n = (b == 0) ? 1 : int'(b);
    err = is_err(a, w, n);
    wi = int'((a / 4) % 512);
    t = cyc;
    ab = 1'b0;
    req = 1'b1; cmd = 1'b0; width = w; addr = a; bl = b; wdata = $urandom;
    e_ack[t] = 1'b1;
    if (err) begin
      for (int k = 0; k < n; k++) e_resp[t+1+k] = 2'd2;
      busy_end = t + n;
    end else begin
      for (int k = 0; k < n; k++) begin
        e_csb[t+1+k]   = 1'b0;
        e_web[t+1+k]   = 1'b1;
        e_addr[t+1+k]  = 9'((wi + k) % 512);
        e_resp[t+2+k]  = (k == n - 1) ? 2'd3 : 2'd1;
        e_rdata[t+2+k] = ref_mem[(wi + k) % 512];
      end
      busy_end = t + n + 2;
    end
    nxt();
    while (cyc < busy_end && !ab) begin
      if (abort_k >= 0 && cyc == t + 1 + abort_k) begin
        for (int c = cyc; c < MAXC; c++) clr(c);
        req = 1'b0;
        rst_n = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
        ab = 1'b1;
      end else begin
        junk(1'($urandom));
        nxt();
      end
    end
    req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] w, input logic [2:0] b,
                    input int gap_at, input int gap_len, input logic [31:0] d0, output int t);
    int n, wi, c, g;
    bit err;
    logic [3:0] m;
    logic [31:0] d;
    n = (b == 0) ? 1 : int'(b);
    err = is_err(a, w, n);
    wi = int'((a / 4) % 512);
    t = cyc;
    for (int k = 0; k < n; k++) begin
      c = cyc;
      if (k == 0) begin
        req = 1'b1; cmd = 1'b1; width = w; addr = a; bl = b; wdata = d0;
      end else begin
        junk(1'b1);
      end
      e_ack[c] = 1'b1;
      if (err) begin
        e_resp[c+1] = 2'd2;
      end else begin
        m = (n > 1) ? 4'hF : lane_mask(w, a);
        d = repl(w, wdata);
        e_csb[c+1]  = 1'b0;
        e_web[c+1]  = 1'b0;
        e_addr[c+1] = 9'((wi + k) % 512);
        e_mask[c+1] = m;
        e_din[c+1]  = d;
        e_resp[c+1] = (k == n - 1) ? 2'd3 : 2'd1;
        for (int i = 0; i < 4; i++)
          if (m[i]) ref_mem[(wi + k) % 512][8*i +: 8] = d[8*i +: 8];
      end
      nxt();
      if (k < n - 1) begin
        g = (gap_at >= 0) ? ((k == gap_at) ? gap_len : 0) : int'($urandom % 3);
        repeat (g) begin
          junk(1'b0);
          nxt();
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic rand_cmd(output logic [31:0] a, output logic [1:0] w, output logic [2:0] b);
    int r, wi;
    r = int'($urandom % 10);
    wi = int'($urandom % 512);
    w = 2'($urandom % 3);
    b = 3'($urandom % 2);
    a = BASE + 32'(wi * 4);
    if (r < 6) begin
      if (w == 2'd0) a = a + ($urandom % 4);
      else if (w == 2'd1) a = a + 2 * ($urandom % 2);
      if (w != 2'd2 && $urandom % 4 == 0) b = 3'(2 + $urandom % 6);
    end else if (r < 8) begin
      w = 2'd2;
      b = 3'($urandom);
    end else if (r == 8) begin
      w = 2'(1 + $urandom % 2);
      a = a + ((w == 2'd1) ? 1 : 1 + $urandom % 3);
    end else begin
      w = 2'd2;
      b = 3'($urandom);
      a = a ^ (32'h1 << $urandom_range(11, 31));
    end
  endtask

  // Compare process: every cycle against the model, plus literal pins
  initial begin
    forever begin
      @(negedge clk);
      if (!done && cyc < MAXC) begin
        chk("resp", 32'(resp), 32'(e_resp[cyc]));
        chk("rdata", rdata, e_rdata[cyc]);
        chk("mem_csb", 32'(mem_csb), 32'(e_csb[cyc]));
        chk("req_ack", 32'(req_ack), 32'(e_ack[cyc]));
        if (!e_csb[cyc]) begin
          chk("mem_web", 32'(mem_web), 32'(e_web[cyc]));
          chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
          if (!e_web[cyc]) begin
            chk("mem_wmask", 32'(mem_wmask), 32'(e_mask[cyc]));
            chk("mem_din", mem_din, e_din[cyc]);
          end
        end
        if (!rst_n) begin
          chk("rst_web", 32'(mem_web), 32'h1);
          chk("rst_wmask", 32'(mem_wmask), 32'h0);
          chk("rst_addr", 32'(mem_addr), 32'h0);
          chk("rst_din", mem_din, 32'h0);
        end
        foreach (lits[i]) begin
          if (lits[i].c == cyc) begin
            case (lits[i].sel)
              S_RESP:  chk("lit_resp", 32'(resp), lits[i].v);
              S_RDATA: chk("lit_rdata", rdata, lits[i].v);
              S_ADDR:  chk("lit_addr", 32'(mem_addr), lits[i].v);
              S_MASK:  chk("lit_wmask", 32'(mem_wmask), lits[i].v);
              S_DIN:   chk("lit_din", mem_din, lits[i].v);
              S_CSB:   chk("lit_csb", 32'(mem_csb), lits[i].v);
              default: chk("lit_ack", 32'(req_ack), lits[i].v);
            endcase
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  w;
    logic [2:0]  b;
    int t;
    for (int i = 0; i < 512; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    for (int c = 0; c < MAXC; c++) clr(c);

    rst_n = 1'b0;
    repeat (3) nxt();
    rst_n = 1'b1;
    nxt();

    wr(BASE + 32'h10, 2'd2, 3'd0, -1, 0, 32'hDEADBEEF, t);
    add_lit(t + 1, S_ADDR, 32'd4);
    add_lit(t + 1, S_MASK, 32'hF);
    add_lit(t + 1, S_RESP, 32'd3);
    rd(BASE + 32'h10, 2'd2, 3'd0, -1, t);
    add_lit(t + 1, S_CSB, 32'd0);
    add_lit(t + 2, S_RDATA, 32'hDEADBEEF);
    add_lit(t + 2, S_RESP, 32'd3);

    wr(BASE + 32'h13, 2'd0, 3'd0, -1, 0, 32'h000000AA, t);
    add_lit(t + 1, S_MASK, 32'h8);
    add_lit(t + 1, S_DIN, 32'hAAAAAAAA);
    rd(BASE + 32'h10, 2'd2, 3'd0, -1, t);
    add_lit(t + 2, S_RDATA, 32'hAAADBEEF);

    rd(BASE + 32'h7F8, 2'd2, 3'd4, -1, t);
    add_lit(t + 1, S_ADDR, 32'd510);
    add_lit(t + 2, S_ADDR, 32'd511);
    add_lit(t + 3, S_ADDR, 32'd0);
    add_lit(t + 4, S_ADDR, 32'd1);
    add_lit(t + 1, S_ACK, 32'd0);
    add_lit(t + 2, S_RESP, 32'd1);
    add_lit(t + 5, S_RESP, 32'd3);

    wr(BASE + 32'h40, 2'd2, 3'd3, 1, 2, 32'h01020304, t);
    add_lit(t + 1, S_RESP, 32'd1);
    add_lit(t + 2, S_RESP, 32'd1);
    add_lit(t + 3, S_RESP, 32'd0);
    add_lit(t + 5, S_RESP, 32'd3);
    add_lit(t + 5, S_CSB, 32'd0);

    rd(BASE + 32'h2000, 2'd2, 3'd0, -1, t);
    add_lit(t + 1, S_RESP, 32'd2);
    add_lit(t + 1, S_CSB, 32'd1);
    rd(BASE + 32'h21, 2'd1, 3'd0, -1, t);
    add_lit(t + 1, S_RESP, 32'd2);
    rd(BASE + 32'h20, 2'd0, 3'd2, -1, t);
    add_lit(t + 1, S_RESP, 32'd2);
    add_lit(t + 2, S_RESP, 32'd2);
    add_lit(t + 2, S_CSB, 32'd1);

    repeat (150) begin
      rand_cmd(a, w, b);
      repeat ($urandom % 3) begin
        junk(1'b0);
        nxt();
      end
      if ($urandom % 2 == 1) wr(a, w, b, -1, 0, $urandom, t);
      else                   rd(a, w, b, -1, t);
    end

    req = 1'b0;
    nxt();
    rd(BASE + 32'h100, 2'd2, 3'd4, 2, t);
    add_lit(t + 2, S_RESP, 32'd1);
    add_lit(t + 3, S_RESP, 32'd0);
    add_lit(t + 3, S_CSB, 32'd1);
    wr(BASE + 32'h104, 2'd2, 3'd0, -1, 0, 32'h12345678, t);
    add_lit(t + 1, S_RESP, 32'd3);
    add_lit(t + 1, S_CSB, 32'd0);
    rd(BASE + 32'h104, 2'd2, 3'd0, -1, t);
    add_lit(t + 2, S_RDATA, 32'h12345678);

    repeat (4) nxt();
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
